// File: rtl/ysyx_22050019_if_id_fifo.sv
// ysyx_22050019_if_id_fifo
// Fetch queue between the IFU and the IDU. Each committed fetch (PC plus
// 32-bit instruction) is captured on the IFU commit strobe into a small
// circular buffer. Entries go to the decoder in order through a valid/ready
// handshake. The IFU is back-pressured through pc_stall_o. A downstream
// redirect (flush_i) drops everything queued.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous reset, active-high despite the name
//   in_valid    fetch commit strobe from the IFU
//   in_pc       PC of the committed instruction
//   in_inst     committed instruction
//   in_ready    queue can accept (not full)
//   pc_stall_o  stall to the IFU (full)
//   flush_i     redirect: drop all entries
//   out_valid   head entry valid
//   out_pc      head PC, 0 when empty
//   out_inst    head instruction, NOP_INST when empty
//   out_ready   IDU accepts the head this cycle
//   count_o     current occupancy
module ysyx_22050019_if_id_fifo #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [63:0]                in_pc,
  input  logic [31:0]                in_inst,
  output logic                       in_ready,
  output logic                       pc_stall_o,
  input  logic                       flush_i,
  output logic                       out_valid,
  output logic [63:0]                out_pc,
  output logic [31:0]                out_inst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Flush wins over both handshakes; a same-cycle fetch is never recorded.
  assign push = in_valid & ~full & ~flush_i;
  assign pop  = ~empty & out_ready & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately unreset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push && !rst_n) begin
      pc_mem_q[wr_ptr_q]   <= in_pc;
      inst_mem_q[wr_ptr_q] <= in_inst;
    end
  end

  assign in_ready   = ~full;
  assign pc_stall_o = full;
  assign out_valid  = ~empty;
  assign out_pc     = empty ? 64'h0 : pc_mem_q[rd_ptr_q];
  assign out_inst   = empty ? NOP_INST : inst_mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: tb/tb_ysyx_22050019_if_id_fifo.sv
module tb_ysyx_22050019_if_id_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        pc_stall_o;
  logic        flush_i;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic [1:0]  count_o;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22050019_if_id_fifo #(.DEPTH(2), .NOP_INST(32'h0000_0013)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .in_ready   (in_ready),
    .pc_stall_o (pc_stall_o),
    .flush_i    (flush_i),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_ready  (out_ready),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".out_pc"},    out_pc,         64'h0);
    check({tag, ".out_inst"},  64'(out_inst),  64'h13);
    check({tag, ".in_ready"},  64'(in_ready),  64'd1);
    check({tag, ".stall"},     64'(pc_stall_o), 64'd0);
    check({tag, ".count"},     64'(count_o),   64'd0);
  endtask

  task automatic push1(input logic [63:0] pc, input logic [31:0] inst);
    in_valid = 1'b1; in_pc = pc; in_inst = inst;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    flush_i = 1'b0; out_ready = 1'b0;

    // Reset then idle
    step(); step();
    rst_n = 1'b0;
    check_reset_state("reset");
    step();
    check_reset_state("idle");

    // Single pass
    push1(64'h8000_0000, 32'h0010_0093);
    check("single.valid", 64'(out_valid), 64'd1);
    check("single.pc",    out_pc,         64'h8000_0000);
    check("single.inst",  64'(out_inst),  64'h0010_0093);
    check("single.count", 64'(count_o),   64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single.pop_valid", 64'(out_valid), 64'd0);
    check("single.pop_count", 64'(count_o),   64'd0);
    check("single.pop_inst",  64'(out_inst),  64'h13);
    check("single.pop_pc",    out_pc,         64'h0);

    // Fill and stall
    push1(64'h8000_0000, 32'h0000_0111);
    push1(64'h8000_0004, 32'h0000_0222);
    check("fill.count", 64'(count_o),    64'd2);
    check("fill.ready", 64'(in_ready),   64'd0);
    check("fill.stall", 64'(pc_stall_o), 64'd1);
    push1(64'h8000_0008, 32'h0000_0333);
    check("fill.ignored_count", 64'(count_o), 64'd2);
    check("fill.head0_pc",   out_pc,        64'h8000_0000);
    check("fill.head0_inst", 64'(out_inst), 64'h111);
    out_ready = 1'b1;
    step();
    check("fill.head1_pc",   out_pc,        64'h8000_0004);
    check("fill.head1_inst", 64'(out_inst), 64'h222);
    check("fill.count1",     64'(count_o),  64'd1);
    check("fill.ready1",     64'(in_ready), 64'd1);
    step();
    check("fill.empty_valid", 64'(out_valid), 64'd0);
    check("fill.empty_count", 64'(count_o),   64'd0);
    out_ready = 1'b0;

    // Streaming with wrap
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_pc    = 64'h8000_0000 + 64'(4 * k);
      in_inst  = 32'h0000_1000 + 32'(k);
      step();
      check($sformatf("stream%0d.pc", k),    out_pc,         64'h8000_0000 + 64'(4 * k));
      check($sformatf("stream%0d.inst", k),  64'(out_inst),  64'h1000 + 64'(k));
      check($sformatf("stream%0d.count", k), 64'(count_o),   64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream.drain_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Flush with a full queue and a competing fetch
    push1(64'h8000_0010, 32'h0000_0444);
    push1(64'h8000_0014, 32'h0000_0555);
    check("flush.pre_count", 64'(count_o), 64'd2);
    in_valid = 1'b1; in_pc = 64'h8000_0100; in_inst = 32'h0000_0666; flush_i = 1'b1;
    step();
    in_valid = 1'b0; flush_i = 1'b0;
    check("flush.count", 64'(count_o),   64'd0);
    check("flush.valid", 64'(out_valid), 64'd0);
    check("flush.ready", 64'(in_ready),  64'd1);
    check("flush.pc",    out_pc,         64'h0);
    step();
    check("flush.later_valid", 64'(out_valid), 64'd0);

    // Flush with room left: the fetch must still be dropped
    push1(64'h8000_0200, 32'h0000_0777);
    check("flush2.pre_pc", out_pc, 64'h8000_0200);
    in_valid = 1'b1; in_pc = 64'h8000_0300; in_inst = 32'h0000_0888;
    flush_i = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
    check("flush2.count", 64'(count_o),   64'd0);
    check("flush2.valid", 64'(out_valid), 64'd0);
    push1(64'h8000_0304, 32'h0000_0999);
    check("flush2.after_pc",    out_pc,        64'h8000_0304);
    check("flush2.after_count", 64'(count_o),  64'd1);

    // Reset priority over flush, with entries queued
    push1(64'h8000_0400, 32'h0000_0aaa);
    check("rstp.pre_count", 64'(count_o), 64'd2);
    rst_n = 1'b1; flush_i = 1'b1; in_valid = 1'b1; in_pc = 64'h8000_0404;
    step();
    rst_n = 1'b0; flush_i = 1'b0; in_valid = 1'b0;
    check_reset_state("rstp");
    push1(64'h8000_0500, 32'h0000_0bbb);
    check("rstp.push_pc",    out_pc,        64'h8000_0500);
    check("rstp.push_inst",  64'(out_inst), 64'hbbb);
    check("rstp.push_count", 64'(count_o),  64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("rstp.pop_count", 64'(count_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_if_id_fifo.md
# ysyx_22050019_if_id_fifo

Fetch queue between the IFU and the IDU. It captures each committed fetch (PC plus 32-bit instruction) on the IFU commit strobe and holds it in a small circular buffer. It presents entries in order to the decoder with a valid/ready handshake. It back-pressures the IFU through its stall input and discards all queued instructions on a control-flow redirect.

## Interface
Parameters:
- DEPTH, 2, number of entries; power of two, ≥2
- NOP_INST, 32'h00000013, instruction presented when empty (addi x0,x0,0)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-high (asserted = 1 resets)
- in_valid  in  1  fetch commit strobe from IFU (inst_commite)
- in_pc  in  64  PC of committed instruction
- in_inst  in  32  committed instruction, already word-selected
- in_ready  out  1  queue can accept; equals ~full
- pc_stall_o  out  1  stall to IFU pc_stall_i; equals full
- flush_i  in  1  redirect/jump resolved downstream; drop all entries
- out_valid  out  1  head entry valid; equals (count != 0)
- out_pc  out  64  head PC; 64'h0 when empty
- out_inst  out  32  head instruction; NOP_INST when empty
- out_ready  in  1  IDU accepts head this cycle (~IDU stall)
- count_o  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH × {pc[63:0], inst[31:0]} registers, write pointer wr_ptr, read pointer rd_ptr, both $clog2(DEPTH) bits, plus count.
- Push = in_valid & in_ready & ~flush_i: mem[wr_ptr] ← {in_pc, in_inst}, wr_ptr +1 (wraps modulo DEPTH).
- Pop = out_valid & out_ready & ~flush_i: rd_ptr +1 (wraps), entry discarded.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when full is impossible: in_ready is 0 when full. When empty, pop is impossible. No bypass from in to out.
- in_valid while in_ready=0: the fetch is ignored. The IFU sees pc_stall_o=1 and does not commit. The queue never records it.
- flush_i=1: next cycle wr_ptr=rd_ptr=0, count=0. Any same-cycle push or pop is suppressed. Flush takes priority over push and pop.
- rst_n has priority over flush_i.
- Storage contents are not reset; outputs are masked when empty.
- Outputs out_valid, out_pc, out_inst, in_ready, pc_stall_o and count_o are decoded from registered state only.

## Timing
- Reset values (cycle after rst_n=1 sampled): out_valid=0, out_pc=0, out_inst=NOP_INST, in_ready=1, pc_stall_o=0, count_o=0.
- Latency: push at edge N makes out_valid=1 with that entry from cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- No combinational paths: in_valid→out_valid, out_ready→in_ready and flush_i→any output are all registered.
- Full boundary: the push that makes count=DEPTH drives in_ready=0 and pc_stall_o=1 next cycle. They stay there until a pop or flush.
- Empty boundary: the pop that makes count=0 drives out_valid=0 next cycle. Masked outputs follow.
- Wrap-around: pointers roll DEPTH−1→0 with no gap or reorder.
- Reset mid-operation: all queued entries are lost. State is identical to power-on reset.

## Test plan
- Reset then idle: hold rst_n=1 for 2 cycles, release. Required: out_valid=0, out_inst=32'h00000013, out_pc=0, in_ready=1, count_o=0.
- Single pass: push pc=0x80000000 inst=0x00100093 with out_ready=0. Next cycle out_valid=1 with that pc/inst and count_o=1. Then out_ready=1 for one cycle. Next cycle out_valid=0 and count_o=0.
- Fill and stall (DEPTH=2): push 0x80000000 and 0x80000004 with out_ready=0. Required: count_o=2, in_ready=0, pc_stall_o=1. A third in_valid (0x80000008) is ignored; after two pops the outputs were 0x80000000 then 0x80000004 only.
- Streaming and wrap: in_valid=out_ready=1 for 10 cycles, PCs 0x80000000+4k. Required: outputs in order, one per cycle after the 1-cycle fill, count_o stays at 1, no loss across pointer wrap.
- Flush: two entries queued, flush_i=1 together with in_valid=1 (pc=0x80000100). Required: next cycle count_o=0, out_valid=0, in_ready=1, and 0x80000100 never appears at the output.
- Reset priority: rst_n=1 and flush_i=1 together with entries queued. Required: reset values next cycle, and a subsequent push behaves as from power-on.
